// File: rtl/usb2_ep_in_seq.sv
// IN-direction packetizer for a double-buffered USB 2.0 endpoint: fills the
// current half-buffer from a byte stream and runs the commit/ack handshake.
//
// state       | meaning
// ST_WAIT_BUF | idle, waiting for a free half-buffer (or issuing a pending ZLP)
// ST_FILL     | accepting bytes into the current half-buffer
// ST_COMMIT   | commit request held until the endpoint acknowledges
// ST_ACK      | waiting for ack to fall while the endpoint swaps halves
module usb2_ep_in_seq #(
  parameter int MAX_PKT      = 512,
  parameter int FLUSH_CYCLES = 1024,
  parameter int ZLP_AUTO     = 1
) (
  input  logic        i_phy_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_s_data,
  input  logic        i_s_valid,
  input  logic        i_s_last,
  input  logic        i_s_flush,
  output logic        o_s_ready,
  output logic [8:0]  o_buf_in_addr,
  output logic [7:0]  o_buf_in_data,
  output logic        o_buf_in_wren,
  input  logic        i_buf_in_ready,
  output logic        o_buf_in_commit,
  output logic [9:0]  o_buf_in_commit_len,
  input  logic        i_buf_in_commit_ack,
  output logic        o_busy,
  output logic [15:0] o_pkt_count
);

  localparam int TW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {ST_WAIT_BUF, ST_FILL, ST_COMMIT, ST_ACK} state_t;

  state_t        r_state;
  logic [9:0]    r_count;
  logic [TW-1:0] r_idle_left;
  logic          r_zlp_pend;
  logic          r_wren;
  logic [8:0]    r_addr;
  logic [7:0]    r_data;
  logic          r_commit;
  logic [9:0]    r_len;
  logic [15:0]   r_pkt_count;

  logic          w_accept;
  logic [9:0]    w_count_nxt;
  logic          w_full;
  logic          w_timeout;

  assign o_s_ready   = (r_state == ST_FILL) && !i_reset;
  assign w_accept    = i_s_valid && o_s_ready;
  assign w_count_nxt = r_count + 10'd1;
  assign w_full      = (w_count_nxt == 10'(MAX_PKT));
  // Idle timer is a down-counter; terminal count 1 means FLUSH_CYCLES idle cycles seen.
  assign w_timeout   = (FLUSH_CYCLES > 0) && (r_count != 10'd0) && (r_idle_left == TW'(1));

  always_ff @(posedge i_phy_clk) begin
    if (i_reset) begin
      r_state     <= ST_WAIT_BUF;
      r_count     <= '0;
      r_idle_left <= '0;
      r_zlp_pend  <= 1'b0;
      r_wren      <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_commit    <= 1'b0;
      r_len       <= '0;
      r_pkt_count <= '0;
    end else begin
      r_wren <= 1'b0;
      case (r_state)
        ST_WAIT_BUF: begin
          if (i_buf_in_ready && !i_buf_in_commit_ack) begin
            if (r_zlp_pend) begin
              r_zlp_pend <= 1'b0;
              r_len      <= '0;
              r_commit   <= 1'b1;
              r_state    <= ST_COMMIT;
            end else begin
              r_state <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            r_wren      <= 1'b1;
            r_addr      <= r_count[8:0];
            r_data      <= i_s_data;
            r_count     <= w_count_nxt;
            r_idle_left <= TW'(FLUSH_CYCLES);
            if (w_full || i_s_last || i_s_flush) begin
              // commit rises one cycle later, after this byte's write is out
              r_len   <= w_count_nxt;
              r_state <= ST_COMMIT;
              if (i_s_last && w_full && (ZLP_AUTO != 0)) r_zlp_pend <= 1'b1;
            end
          end else if (i_s_flush || w_timeout) begin
            r_len    <= r_count;
            r_commit <= 1'b1;
            r_state  <= ST_COMMIT;
          end else if ((r_count != 10'd0) && (r_idle_left != '0)) begin
            r_idle_left <= r_idle_left - TW'(1);
          end
        end
        ST_COMMIT: begin
          if (!r_commit) begin
            r_commit <= 1'b1;
          end else if (i_buf_in_commit_ack) begin
            r_commit <= 1'b0;
            r_state  <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!i_buf_in_commit_ack) begin
            r_pkt_count <= r_pkt_count + 16'd1;
            r_count     <= '0;
            r_state     <= ST_WAIT_BUF;
          end
        end
        default: r_state <= ST_WAIT_BUF;
      endcase
    end
  end

  assign o_buf_in_addr       = r_addr;
  assign o_buf_in_data       = r_data;
  assign o_buf_in_wren       = r_wren;
  assign o_buf_in_commit     = r_commit;
  assign o_buf_in_commit_len = r_len;
  assign o_pkt_count         = r_pkt_count;
  assign o_busy              = !((r_state == ST_WAIT_BUF) && (r_count == 10'd0));

endmodule

// File: tb/tb_usb2_ep_in_seq.sv
// Directed bench for usb2_ep_in_seq: a cycle table for the basic handshake
// plus hand-written sequences for streaming, timeout, back-pressure and reset.
module tb_usb2_ep_in_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_flush = 1'b0;
  logic        s_ready;
  logic [8:0]  addr;
  logic [7:0]  data;
  logic        wren;
  logic        brdy = 1'b0;
  logic        commit;
  logic [9:0]  len;
  logic        ack = 1'b0;
  logic        busy;
  logic [15:0] pkt;

  always #5 clk = ~clk;

  usb2_ep_in_seq #(.MAX_PKT(512), .FLUSH_CYCLES(16), .ZLP_AUTO(1)) dut (
    .i_phy_clk(clk), .i_reset(rst), .i_s_data(s_data), .i_s_valid(s_valid),
    .i_s_last(s_last), .i_s_flush(s_flush), .o_s_ready(s_ready),
    .o_buf_in_addr(addr), .o_buf_in_data(data), .o_buf_in_wren(wren),
    .i_buf_in_ready(brdy), .o_buf_in_commit(commit), .o_buf_in_commit_len(len),
    .i_buf_in_commit_ack(ack), .o_busy(busy), .o_pkt_count(pkt)
  );

  typedef struct packed {
    logic rst, vld; logic [7:0] dat; logic lst, fls, brdy, ack;
    logic e_rdy, e_wren; logic [8:0] e_addr; logic [7:0] e_data;
    logic e_com; logic [9:0] e_len; logic e_busy; logic [15:0] e_pkt;
  } vec_t;
  vec_t tbl[20];

  int n_vec = 0, n_err = 0, cyc = 0;
  int q_addr[$], q_data[$], q_len[$];
  bit prev_com = 0, auto_ack = 0;
  int ack_delay = 1, ack_len = 1, ack_wait = 0, ack_hold = 0;
  int com_hi_cyc = 0, rdy_during_ack = 0, com_rise_cyc = 0, last_acc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1; cyc++;
    if (wren === 1'b1) begin q_addr.push_back(int'(addr)); q_data.push_back(int'(data)); end
    if (commit === 1'b1 && !prev_com) begin q_len.push_back(int'(len)); com_rise_cyc = cyc; end
    prev_com = (commit === 1'b1);
    if (commit === 1'b1) com_hi_cyc++;
    if (s_ready === 1'b1 && ack === 1'b1) rdy_during_ack++;
    if (auto_ack) begin
      if (ack) begin
        ack_hold++;
        if (ack_hold >= ack_len) begin ack = 1'b0; ack_hold = 0; end
      end else if (commit === 1'b1) begin
        ack_wait++;
        if (ack_wait >= ack_delay) begin ack = 1'b1; ack_wait = 0; end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ack = 1'b0; ack_wait = 0; ack_hold = 0;
    s_valid = 1'b0; s_last = 1'b0; s_flush = 1'b0;
    step(); step();
    rst = 1'b0;
    q_addr.delete(); q_data.delete(); q_len.delete();
    prev_com = 0; com_hi_cyc = 0; rdy_during_ack = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int b = 0;
    s_data = d; s_last = l; s_valid = 1'b1;
    while (s_ready !== 1'b1 && b < 200) begin step(); b++; end
    if (b >= 200) chk("send_ready_timeout", 32'(b), 32'd0);
    else begin step(); last_acc = cyc; end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad, b, wc, rc;
    //          rst  vld  dat    lst  fls  brdy ack  | rdy  wren addr  data   com  len    busy pkt
    tbl[0]  = '{1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,9'd0, 8'h00, 1'b0,10'd0, 1'b0,16'd0};
    tbl[1]  = '{1'b0,1'b1,8'hA1, 1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,9'd0, 8'h00, 1'b0,10'd0, 1'b1,16'd0};
    tbl[2]  = '{1'b0,1'b1,8'hA1, 1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,9'd0, 8'hA1, 1'b0,10'd0, 1'b1,16'd0};
    tbl[3]  = '{1'b0,1'b1,8'hB2, 1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,9'd1, 8'hB2, 1'b0,10'd0, 1'b1,16'd0};
    tbl[4]  = '{1'b0,1'b0,8'hB2, 1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,9'd1, 8'hB2, 1'b0,10'd0, 1'b1,16'd0};
    tbl[5]  = '{1'b0,1'b1,8'hC3, 1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,9'd2, 8'hC3, 1'b0,10'd3, 1'b1,16'd0};
    tbl[6]  = '{1'b0,1'b0,8'hC3, 1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,9'd2, 8'hC3, 1'b1,10'd3, 1'b1,16'd0};
    tbl[7]  = '{1'b0,1'b0,8'hC3, 1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,9'd2, 8'hC3, 1'b1,10'd3, 1'b1,16'd0};
    tbl[8]  = '{1'b0,1'b0,8'hC3, 1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,9'd2, 8'hC3, 1'b0,10'd3, 1'b1,16'd0};
    tbl[9]  = '{1'b0,1'b0,8'hC3, 1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,9'd2, 8'hC3, 1'b0,10'd3, 1'b1,16'd0};
    tbl[10] = '{1'b0,1'b0,8'hC3, 1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,9'd2, 8'hC3, 1'b0,10'd3, 1'b0,16'd1};
    tbl[11] = '{1'b0,1'b0,8'hC3, 1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,9'd2, 8'hC3, 1'b0,10'd3, 1'b1,16'd1};
    tbl[12] = '{1'b0,1'b0,8'hC3, 1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,9'd2, 8'hC3, 1'b1,10'd0, 1'b1,16'd1};
    tbl[13] = '{1'b0,1'b0,8'hC3, 1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,9'd2, 8'hC3, 1'b0,10'd0, 1'b1,16'd1};
    tbl[14] = '{1'b0,1'b0,8'hC3, 1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,9'd2, 8'hC3, 1'b0,10'd0, 1'b0,16'd2};
    tbl[15] = '{1'b0,1'b0,8'hC3, 1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,9'd2, 8'hC3, 1'b0,10'd0, 1'b1,16'd2};
    tbl[16] = '{1'b0,1'b1,8'hD4, 1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,9'd0, 8'hD4, 1'b0,10'd1, 1'b1,16'd2};
    tbl[17] = '{1'b0,1'b0,8'hD4, 1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,9'd0, 8'hD4, 1'b1,10'd1, 1'b1,16'd2};
    tbl[18] = '{1'b0,1'b0,8'hD4, 1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,9'd0, 8'hD4, 1'b1,10'd1, 1'b1,16'd2};
    tbl[19] = '{1'b1,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,9'd0, 8'h00, 1'b0,10'd0, 1'b0,16'd0};

    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst; s_valid = tbl[i].vld; s_data = tbl[i].dat; s_last = tbl[i].lst;
      s_flush = tbl[i].fls; brdy = tbl[i].brdy; ack = tbl[i].ack;
      step();
      chk($sformatf("row%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d_wren", i),    32'(wren),    32'(tbl[i].e_wren));
      chk($sformatf("row%0d_addr", i),    32'(addr),    32'(tbl[i].e_addr));
      chk($sformatf("row%0d_data", i),    32'(data),    32'(tbl[i].e_data));
      chk($sformatf("row%0d_commit", i),  32'(commit),  32'(tbl[i].e_com));
      chk($sformatf("row%0d_len", i),     32'(len),     32'(tbl[i].e_len));
      chk($sformatf("row%0d_busy", i),    32'(busy),    32'(tbl[i].e_busy));
      chk($sformatf("row%0d_pkt", i),     32'(pkt),     32'(tbl[i].e_pkt));
    end
    s_valid = 1'b0; s_flush = 1'b0; s_last = 1'b0;

    // 1024-byte transfer ending on a packet boundary: two full packets plus a ZLP
    do_reset();
    brdy = 1'b1; auto_ack = 1; ack_delay = 1; ack_len = 1;
    for (int i = 0; i < 1024; i++) send(i[7:0], i == 1023);
    repeat (30) step();
    chk("A_ncommits", 32'(q_len.size()), 32'd3);
    chk("A_len0", (q_len.size() > 0) ? 32'(q_len[0]) : 32'hFFFF, 32'd512);
    chk("A_len1", (q_len.size() > 1) ? 32'(q_len[1]) : 32'hFFFF, 32'd512);
    chk("A_len2", (q_len.size() > 2) ? 32'(q_len[2]) : 32'hFFFF, 32'd0);
    chk("A_nwrites", 32'(q_addr.size()), 32'd1024);
    bad = 0;
    for (int i = 0; i < q_addr.size() && i < 1024; i++)
      if (q_addr[i] != (i % 512) || q_data[i] != (i % 256)) bad++;
    chk("A_addr_data_bad", 32'(bad), 32'd0);
    chk("A_pkt_count", 32'(pkt), 32'd3);

    // 10 bytes then idle: short packet committed 16 cycles after the last accept
    do_reset();
    brdy = 1'b1; ack_delay = 1; ack_len = 1;
    step();
    for (int i = 0; i < 10; i++) send(8'h10 + 8'(i), 1'b0);
    b = 0;
    while (q_len.size() == 0 && b < 100) begin step(); b++; end
    if (q_len.size() == 0) chk("B_commit_timeout", 32'(b), 32'd0);
    else chk("B_commit_delay", 32'(com_rise_cyc - last_acc), 32'd16);
    repeat (60) step();
    chk("B_ncommits", 32'(q_len.size()), 32'd1);
    chk("B_len", (q_len.size() > 0) ? 32'(q_len[0]) : 32'hFFFF, 32'd10);

    // back-pressure from the endpoint plus a delayed, 4-cycle ack
    do_reset();
    brdy = 1'b1; ack_delay = 3; ack_len = 4;
    step();
    brdy = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h40 + 8'(i), i == 4);
    s_data = 8'h5A; s_valid = 1'b1;
    wc = q_addr.size(); rc = 0;
    repeat (25) begin step(); if (s_ready === 1'b1) rc++; end
    chk("C_ready_held_low", 32'(rc), 32'd0);
    chk("C_no_writes", 32'(q_addr.size() - wc), 32'd0);
    chk("C_commit_hi_cycles", 32'(com_hi_cyc), 32'd3);
    chk("C_len", (q_len.size() > 0) ? 32'(q_len[0]) : 32'hFFFF, 32'd5);
    chk("C_pkt_count", 32'(pkt), 32'd1);
    brdy = 1'b1;
    send(8'h5A, 1'b0);
    chk("C_resume_addr", (q_addr.size() > wc) ? 32'(q_addr[$]) : 32'hFFFF, 32'd0);
    chk("C_resume_data", (q_data.size() > wc) ? 32'(q_data[$]) : 32'hFFFF, 32'h5A);
    chk("C_ready_during_ack", 32'(rdy_during_ack), 32'd0);

    // reset in the middle of a packet discards it and clears every output
    for (int i = 0; i < 100; i++) send(i[7:0], 1'b0);
    rst = 1'b1;
    step();
    chk("D_s_ready", 32'(s_ready), 32'd0);
    chk("D_wren",    32'(wren),    32'd0);
    chk("D_addr",    32'(addr),    32'd0);
    chk("D_data",    32'(data),    32'd0);
    chk("D_commit",  32'(commit),  32'd0);
    chk("D_len",     32'(len),     32'd0);
    chk("D_busy",    32'(busy),    32'd0);
    chk("D_pkt",     32'(pkt),     32'd0);
    rst = 1'b0;
    step();
    wc = q_addr.size();
    send(8'h77, 1'b0);
    chk("D_next_addr", (q_addr.size() > wc) ? 32'(q_addr[$]) : 32'hFFFF, 32'd0);
    chk("D_next_data", (q_data.size() > wc) ? 32'(q_data[$]) : 32'hFFFF, 32'h77);
    chk("D_pkt_after", 32'(pkt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
